// File: rtl/portamento_scanner.sv
// Time-multiplexes one shared portamento smoother across NCOMAX+1 units.
// Each sample_tick runs one 4-cycle present/wait/wait/capture slot per unit.
module portamento_scanner #(
    parameter int SEL_WIDTH = 2,
    parameter int NCOMAX    = 3,
    parameter int DSZ       = 48
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_tick,
    input  logic                        tgt_we,
    input  logic        [SEL_WIDTH-1:0] tgt_unit,
    input  logic signed [DSZ-1:0]       tgt_data,
    output logic        [SEL_WIDTH-1:0] unit,
    output logic signed [DSZ-1:0]       porta_in,
    output logic                        portamento_clk,
    input  logic signed [DSZ-1:0]       porta_out,
    output logic        [SEL_WIDTH-1:0] result_unit,
    output logic signed [DSZ-1:0]       result_data,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        scan_done,
    output logic                        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(NCOMAX);

    state_t                 r_state;
    logic                   r_wcnt;
    logic signed [DSZ-1:0]  r_tgt [0:NCOMAX];
    logic [SEL_WIDTH-1:0]   r_unit;
    logic signed [DSZ-1:0]  r_porta_in;
    logic                   r_pclk;
    logic [SEL_WIDTH-1:0]   r_runit;
    logic signed [DSZ-1:0]  r_rdata;
    logic                   r_rvalid;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;

    logic                   w_tgt_ok;
    logic [SEL_WIDTH-1:0]   w_pres_unit;
    logic signed [DSZ-1:0]  w_pres_data;

    assign w_tgt_ok    = ({1'b0, tgt_unit} <= (SEL_WIDTH+1)'(NCOMAX));
    assign w_pres_unit = (r_state == S_IDLE) ? '0 : r_unit + SEL_WIDTH'(1);

    // A write landing on the same edge as the slot start must be seen.
    always_comb begin
        w_pres_data = r_tgt[w_pres_unit];
        if (tgt_we && (tgt_unit == w_pres_unit))
            w_pres_data = tgt_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NCOMAX; i++)
                r_tgt[i] <= '0;
        end else if (tgt_we && w_tgt_ok) begin
            r_tgt[tgt_unit] <= tgt_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wcnt     <= 1'b0;
            r_unit     <= '0;
            r_porta_in <= '0;
            r_pclk     <= 1'b0;
            r_runit    <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_pclk   <= 1'b0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            if (sample_tick && (r_state != S_IDLE))
                r_overrun <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_state    <= S_PRESENT;
                        r_unit     <= w_pres_unit;
                        r_porta_in <= w_pres_data;
                        r_pclk     <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    r_state <= S_WAIT;
                    r_wcnt  <= 1'b0;
                end
                S_WAIT: begin
                    r_wcnt <= 1'b1;
                    if (r_wcnt)
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rdata  <= porta_out;
                    r_runit  <= r_unit;
                    r_rvalid <= 1'b1;
                    if (r_unit == LAST) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state    <= S_PRESENT;
                        r_unit     <= w_pres_unit;
                        r_porta_in <= w_pres_data;
                        r_pclk     <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign unit           = r_unit;
    assign porta_in       = r_porta_in;
    assign portamento_clk = r_pclk;
    assign result_unit    = r_runit;
    assign result_data    = r_rdata;
    assign result_valid   = r_rvalid;
    assign busy           = r_busy;
    assign scan_done      = r_done;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_portamento_scanner.sv
// Bench for portamento_scanner: slot-arithmetic reference model, directed
// scenarios and a randomized tick/write phase, smoother looped back as +1.
module tb_portamento_scanner;

    localparam int SW    = 2;
    localparam int NC    = 3;
    localparam int DW    = 48;
    localparam int SLOTS = NC + 1;
    localparam int SCAN  = 4 * SLOTS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sample_tick = 1'b0;
    logic                 tgt_we = 1'b0;
    logic [SW-1:0]        tgt_unit = '0;
    logic signed [DW-1:0] tgt_data = '0;
    logic [SW-1:0]        unit;
    logic [SW-1:0]        result_unit;
    logic signed [DW-1:0] porta_in;
    logic signed [DW-1:0] porta_out;
    logic signed [DW-1:0] result_data;
    logic                 portamento_clk;
    logic                 result_valid;
    logic                 busy;
    logic                 scan_done;
    logic                 overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign porta_out = porta_in + DW'(1);

    portamento_scanner #(
        .SEL_WIDTH(SW),
        .NCOMAX(NC),
        .DSZ(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_tick(sample_tick),
        .tgt_we(tgt_we),
        .tgt_unit(tgt_unit),
        .tgt_data(tgt_data),
        .unit(unit),
        .porta_in(porta_in),
        .portamento_clk(portamento_clk),
        .porta_out(porta_out),
        .result_unit(result_unit),
        .result_data(result_data),
        .result_valid(result_valid),
        .busy(busy),
        .scan_done(scan_done),
        .overrun(overrun)
    );

    // Reference model: m_t counts cycles since the accepted tick (0 = idle).
    logic signed [DW-1:0] m_tgt [SLOTS];
    int                   m_t;
    logic [SW-1:0]        m_unit;
    logic [SW-1:0]        m_runit;
    logic signed [DW-1:0] m_pin;
    logic signed [DW-1:0] m_rdata;
    logic                 m_pclk;
    logic                 m_rvalid;
    logic                 m_done;
    logic                 m_ovr;

    int rel;
    int cnt_pclk;
    int cnt_rv;
    int cnt_done;
    int cnt_busy;
    int q_pt[$];
    int q_pu[$];
    logic signed [DW-1:0] q_pi[$];
    logic signed [DW-1:0] q_rd[$];
    int q_ru[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++)
            m_tgt[i] = '0;
        m_t      = 0;
        m_unit   = '0;
        m_runit  = '0;
        m_pin    = '0;
        m_rdata  = '0;
        m_pclk   = 1'b0;
        m_rvalid = 1'b0;
        m_done   = 1'b0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge(input logic tk, input logic we,
                              input logic [SW-1:0] u,
                              input logic signed [DW-1:0] d);
        int old_t;
        old_t    = m_t;
        m_pclk   = 1'b0;
        m_rvalid = 1'b0;
        m_done   = 1'b0;
        if (tk && old_t != 0)
            m_ovr = 1'b1;
        if (old_t != 0 && old_t % 4 == 0) begin
            m_rvalid = 1'b1;
            m_runit  = SW'(old_t / 4 - 1);
            m_rdata  = m_pin + DW'(1);
        end
        if (old_t == SCAN)
            m_done = 1'b1;
        if (we)
            m_tgt[u] = d;
        if (old_t != 0)
            m_t = (old_t == SCAN) ? 0 : old_t + 1;
        else if (tk)
            m_t = 1;
        if (m_t != 0 && (m_t - 1) % 4 == 0) begin
            m_pclk = 1'b1;
            m_unit = SW'((m_t - 1) / 4);
            m_pin  = m_tgt[m_unit];
        end
    endtask

    task automatic check_all();
        chk("unit", 64'(unit), 64'(m_unit));
        chk("porta_in", porta_in, m_pin);
        chk("portamento_clk", 64'(portamento_clk), 64'(m_pclk));
        chk("result_valid", 64'(result_valid), 64'(m_rvalid));
        chk("result_unit", 64'(result_unit), 64'(m_runit));
        chk("result_data", result_data, m_rdata);
        chk("busy", 64'(busy), 64'(m_t != 0));
        chk("scan_done", 64'(scan_done), 64'(m_done));
        chk("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic clear_obs();
        rel = 0;
        cnt_pclk = 0;
        cnt_rv = 0;
        cnt_done = 0;
        cnt_busy = 0;
        q_pt.delete();
        q_pu.delete();
        q_pi.delete();
        q_rd.delete();
        q_ru.delete();
    endtask

    // One clock: drive at negedge, model at posedge, check at next negedge.
    task automatic cyc(input logic tk, input logic we,
                       input logic [SW-1:0] u,
                       input logic signed [DW-1:0] d);
        sample_tick = tk;
        tgt_we      = we;
        tgt_unit    = u;
        tgt_data    = d;
        @(posedge clk);
        model_edge(tk, we, u, d);
        @(negedge clk);
        sample_tick = 1'b0;
        tgt_we      = 1'b0;
        rel++;
        cnt_pclk += int'(portamento_clk);
        cnt_rv   += int'(result_valid);
        cnt_done += int'(scan_done);
        cnt_busy += int'(busy);
        if (portamento_clk) begin
            q_pt.push_back(rel);
            q_pu.push_back(int'(unit));
            q_pi.push_back(porta_in);
        end
        if (result_valid) begin
            q_rd.push_back(result_data);
            q_ru.push_back(int'(result_unit));
        end
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, '0, '0);
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_unit", 64'(unit), 64'd0);
        chk("rst_porta_in", porta_in, 64'd0);
        chk("rst_pclk", 64'(portamento_clk), 64'd0);
        chk("rst_result_unit", 64'(result_unit), 64'd0);
        chk("rst_result_data", result_data, 64'd0);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_scan_done", 64'(scan_done), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        model_reset();
        sample_tick = 1'b0;
        tgt_we      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        logic [63:0] rnd;
        model_reset();
        @(negedge clk);
        do_reset();

        // Basic scan with targets 0x100..0x400 and +1 loopback.
        for (int i = 0; i < SLOTS; i++)
            cyc(1'b0, 1'b1, SW'(i), DW'((i + 1) * 256));
        clear_obs();
        cyc(1'b1, 1'b0, '0, '0);
        idle(19);
        chk("n_pclk", 64'(cnt_pclk), 64'd4);
        chk("n_done", 64'(cnt_done), 64'd1);
        chk("n_busy", 64'(cnt_busy), 64'd16);
        chk("n_rvalid", 64'(cnt_rv), 64'd4);
        for (int i = 0; i < SLOTS; i++) begin
            if (i < q_pt.size()) begin
                chk("pclk_cycle", 64'(q_pt[i]), 64'(4 * i + 1));
                chk("pclk_unit", 64'(q_pu[i]), 64'(i));
                chk("pclk_porta_in", q_pi[i], 64'((i + 1) * 256));
            end
            if (i < q_rd.size()) begin
                chk("res_data", q_rd[i], 64'((i + 1) * 256 + 1));
                chk("res_unit", 64'(q_ru[i]), 64'(i));
            end
        end

        // Write to unit 2 during its own wait: old value this scan.
        cyc(1'b1, 1'b0, '0, '0);
        idle(9);
        cyc(1'b0, 1'b1, SW'(2), DW'(48'h999));
        chk("wr_same_slot_pin", porta_in, 64'h300);
        idle(6);
        cyc(1'b1, 1'b0, '0, '0);
        idle(8);
        chk("wr_next_scan_unit", 64'(unit), 64'd2);
        chk("wr_next_scan_pin", porta_in, 64'h999);
        idle(8);

        // Reset during unit 1 wait, then quiet until a new tick.
        cyc(1'b1, 1'b0, '0, '0);
        idle(5);
        do_reset();
        clear_obs();
        idle(6);
        chk("post_rst_pclk", 64'(cnt_pclk), 64'd0);
        chk("post_rst_rvalid", 64'(cnt_rv), 64'd0);
        cyc(1'b1, 1'b0, '0, '0);
        chk("post_rst_unit", 64'(unit), 64'd0);
        chk("post_rst_pclk1", 64'(portamento_clk), 64'd1);
        idle(19);

        // Write and tick together on unit 0.
        cyc(1'b1, 1'b1, '0, DW'(48'h555));
        chk("wr_tick_pin", porta_in, 64'h555);
        idle(15);
        chk("pre_final_ovr", 64'(overrun), 64'd0);
        cyc(1'b1, 1'b0, '0, '0);
        chk("final_cap_ovr", 64'(overrun), 64'd1);
        chk("final_cap_done", 64'(scan_done), 64'd1);
        chk("final_cap_busy", 64'(busy), 64'd0);
        idle(3);

        // Second tick three cycles into a scan.
        do_reset();
        clear_obs();
        cyc(1'b1, 1'b0, '0, '0);
        idle(2);
        cyc(1'b1, 1'b0, '0, '0);
        chk("ovr_set", 64'(overrun), 64'd1);
        idle(16);
        chk("ovr_slots", 64'(cnt_pclk), 64'd4);
        cyc(1'b1, 1'b0, '0, '0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        idle(19);

        // Randomized ticks and writes against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rnd = {$urandom(), $urandom()};
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                SW'($urandom_range(0, NC)), rnd[DW-1:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
